dyn_adder_n: RTL and testbench

//  Parametrised variable-latency adder with a valid/ready handshake on both sides.

---
 rtl/dyn_adder_pkg.sv | 16 +
 rtl/dyn_adder_n_prop_run_detect.sv | 18 +
 rtl/dyn_adder_n.sv | 127 ++++++++++++
 tb/tb_dyn_adder_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dyn_adder_pkg.sv
// Shared types and helpers for the variable-latency adder.
package dyn_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STATS_W = 16;

    function automatic int lat_sel(input logic slow, input int fast_lat, input int slow_lat);
        return slow ? slow_lat : fast_lat;
    endfunction

endpackage

// File: rtl/dyn_adder_n_prop_run_detect.sv
// Flags any window of RUN_LEN consecutive propagate bits (p = a ^ b).
module prop_run_detect #(
    parameter int WIDTH   = 32,
    parameter int RUN_LEN = 4
) (
    input  logic [WIDTH-1:0] i_p,
    output logic             o_slow
);

    logic [WIDTH-RUN_LEN:0] w_win;

    for (genvar gi = 0; gi <= WIDTH - RUN_LEN; gi++) begin : g_win
        assign w_win[gi] = &i_p[gi +: RUN_LEN];
    end

    assign o_slow = |w_win;

endmodule

// File: rtl/dyn_adder_n.sv
// Variable-latency adder with valid/ready on both sides; optional slow-op
// statistics counter enabled by DYN_ADDER_STATS_EN.
//
// state | meaning
// IDLE  | no result held, ready for operands
// BUSY  | result registered, latency counter draining
// DONE  | result presented on out_valid, waiting for out_ready
module dyn_adder_n
    import dyn_adder_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int RUN_LEN  = 4,
    parameter int FAST_LAT = 1,
    parameter int SLOW_LAT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               slow
`ifdef DYN_ADDER_STATS_EN
    ,
    output logic [STATS_W-1:0] slow_count
`endif
);

    localparam int CNT_W = $clog2(SLOW_LAT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_load;
    logic               w_slow;
    logic               w_accept;
    logic               w_lat_one;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_slow;

    prop_run_detect #(
        .WIDTH   (WIDTH),
        .RUN_LEN (RUN_LEN)
    ) u_run (
        .i_p    (a ^ b),
        .o_slow (w_slow)
    );

    assign w_cnt_load = CNT_W'(lat_sel(w_slow, FAST_LAT, SLOW_LAT) - 1);
    assign w_lat_one  = (w_cnt_load == '0);
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter holds edges still to wait; DONE is entered on the edge that drains it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_lat_one ? DONE : BUSY;
            BUSY: if (r_cnt <= CNT_W'(1)) w_state_nxt = DONE;
            DONE: begin
                if (out_ready) begin
                    if (w_accept) w_state_nxt = w_lat_one ? DONE : BUSY;
                    else          w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (r_state == DONE);
        in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_cnt_load;
        end else if ((r_state == BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_slow <= 1'b0;
        end else if (w_accept) begin
            {r_cout, r_sum} <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            r_slow          <= w_slow;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign slow = r_slow;

`ifdef DYN_ADDER_STATS_EN
    logic [STATS_W-1:0] r_slow_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slow_count <= '0;
        end else if (w_accept && w_slow && (r_slow_count != '1)) begin
            r_slow_count <= r_slow_count + 1'b1;
        end
    end

    assign slow_count = r_slow_count;
`endif

endmodule

// File: tb/tb_dyn_adder_n.sv
// Self-checking bench for dyn_adder_n: vector table, random ops, backpressure,
// reset mid-op, and slow-op statistics when DYN_ADDER_STATS_EN is defined.
module tb_dyn_adder_n;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         slow;
`ifdef DYN_ADDER_STATS_EN
    logic [15:0]  slow_count;
`endif

    dyn_adder_n #(
        .WIDTH    (32),
        .RUN_LEN  (4),
        .FAST_LAT (1),
        .SLOW_LAT (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .slow       (slow)
`ifdef DYN_ADDER_STATS_EN
        ,
        .slow_count (slow_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        slow;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        slow;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic model_slow(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p;
        int          run;
        logic        s;
        p   = x ^ y;
        run = 0;
        s   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (p[i]) run++;
            else      run = 0;
            if (run >= 4) s = 1'b1;
        end
        return s;
    endfunction

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic ic,
                         input logic [31:0] esum, input logic ecout, input logic eslow);
        int   guard;
        exp_t e;
        guard    = 0;
        a        = ia;
        b        = ib;
        cin      = ic;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("issue_in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        e.sum  = esum;
        e.cout = ecout;
        e.slow = eslow;
        e.lat  = eslow ? 3 : 1;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Called right after issue(); counts edges from the accept edge (inclusive).
    task automatic collect(input string name);
        int   edges;
        exp_t e;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, "_out_valid"}, 64'(out_valid), 64'd1);
        if (sb.size() == 0) begin
            check({name, "_scoreboard_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_latency"}, 64'(edges), 64'(e.lat));
        check({name, "_sum"}, 64'(sum), 64'(e.sum));
        check({name, "_cout"}, 64'(cout), 64'(e.cout));
        check({name, "_slow"}, 64'(slow), 64'(e.slow));
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb, hold_sum;
        logic        rc, hold_cout;
        logic [32:0] full;

        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
        vecs[5] = '{32'hF000_0000, 32'h0000_0000, 1'b0, 32'hF000_0000, 1'b0, 1'b1};
        vecs[6] = '{32'h0000_000F, 32'h0000_0000, 1'b1, 32'h0000_0010, 1'b0, 1'b1};
        vecs[7] = '{32'h7777_7777, 32'h0000_0000, 1'b0, 32'h7777_7777, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_000A, 32'h0000_0005, 1'b0, 32'h0000_000F, 1'b0, 1'b1};
        vecs[9] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0};

        // Reset values while reset is held
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_slow", 64'(slow), 64'd0);
        do_reset();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Vector table, issued back to back (drain and accept share an edge)
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].slow);
            collect($sformatf("vec%0d", i));
        end

        // Random operands against the bench model
        for (int i = 0; i < 8; i++) begin
            ra   = $urandom();
            rb   = (i % 2 == 0) ? ~ra ^ (32'h1 << (i * 3)) : $urandom();
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            issue(ra, rb, rc, full[31:0], full[32], model_slow(ra, rb));
            collect($sformatf("rnd%0d", i));
        end

        // Backpressure: hold result for 5 cycles, then drain and accept on one edge
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(32'h0000_FFFF, 32'h0, 1'b1, 32'h0001_0000, 1'b0, 1'b1);
        collect("bp");
        hold_sum  = sum;
        hold_cout = cout;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("bp_hold_sum%0d", i), 64'(sum), 64'(hold_sum));
            check($sformatf("bp_hold_cout%0d", i), 64'(cout), 64'(hold_cout));
            check($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
        end
        a         = 32'd5;
        b         = 32'd6;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        issue(32'd5, 32'd6, 1'b0, 32'd11, 1'b0, 1'b0);
        collect("bp_next");

        // Reset during a slow op in BUSY
        @(posedge clk);
        #1;
        issue(32'hFFFF_0000, 32'h0, 1'b0, 32'hFFFF_0000, 1'b0, 1'b1);
        check("mid_busy_not_valid", 64'(out_valid), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_slow", 64'(slow), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("mid_rel_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("mid_no_spurious%0d", i), 64'(out_valid), 64'd0);
        end
        issue(32'd100, 32'd23, 1'b1, 32'd124, 1'b0, 1'b0);
        collect("after_rst");

`ifdef DYN_ADDER_STATS_EN
        do_reset();
        check("stats_rst", 64'(slow_count), 64'd0);
        issue(32'h0000_00F0, 32'h0, 1'b0, 32'h0000_00F0, 1'b0, 1'b1);
        collect("st0");
        issue(32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);
        collect("st1");
        issue(32'h0F00_0000, 32'h0, 1'b0, 32'h0F00_0000, 1'b0, 1'b1);
        collect("st2");
        issue(32'd4, 32'd8, 1'b1, 32'd13, 1'b0, 1'b0);
        collect("st3");
        issue(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
        collect("st4");
        check("stats_count3", 64'(slow_count), 64'd3);
        @(posedge clk);
        #1;
        force dut.r_slow_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.r_slow_count;
        issue(32'h0000_FFFF, 32'h0, 1'b0, 32'h0000_FFFF, 1'b0, 1'b1);
        collect("st5");
        check("stats_ffff", 64'(slow_count), 64'hFFFF);
        issue(32'h0000_FFFF, 32'h0, 1'b1, 32'h0001_0000, 1'b0, 1'b1);
        collect("st6");
        check("stats_saturate", 64'(slow_count), 64'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
